pp_mult_sched: RTL and testbench

Sequential 8x8 unsigned multiplier that splits each operand into 4-bit halves and time-multiplexes a single 4x4 sub-multiplier across the four partial products, one per cycle, shifting and accumulating each into a 16-bit result. A per-transaction mask selects which partial products are approximated: the mask truncates the low TRUNC_BITS bits of those partial products. The block sits in front of the approximate-multiplier datapath and lets callers trade accuracy for area through a valid/ready interface.

---
 rtl/pp_mult_sched.sv | 124 ++++++++++++
 tb/tb_pp_mult_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_mult_sched.sv
// Sequential 8x8 unsigned multiplier. One 4x4 sub-multiplier is reused across
// four partial products. A per-transaction mask can truncate individual partial products.
module pp_mult_sched #(
  parameter int WIDTH      = 8,
  parameter int TRUNC_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           approx_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Clears the low TRUNC_BITS bits of an approximated partial product.
  localparam logic [WIDTH-1:0] TRUNC_MASK = {WIDTH{1'b1}} << TRUNC_BITS;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         mask_q, mask_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [1:0]         step_q, step_d;
  logic [2*WIDTH-1:0] y_q, y_d;

  logic [HALF-1:0]    op_a, op_b;
  logic [WIDTH-1:0]   pp_raw, pp;
  logic [2*WIDTH-1:0] pp_ext, pp_shift, acc_sum;

  // Step bit 1 selects the high half of a, step bit 0 the high half of b.
  // That gives the fixed order aL*bL, aL*bH, aH*bL, aH*bH.
  assign op_a    = step_q[1] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
  assign op_b    = step_q[0] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
  assign pp_raw  = {{HALF{1'b0}}, op_a} * {{HALF{1'b0}}, op_b};
  assign pp      = mask_q[step_q] ? (pp_raw & TRUNC_MASK) : pp_raw;
  assign pp_ext  = {{WIDTH{1'b0}}, pp};

  always_comb begin
    pp_shift = pp_ext;
    case (step_q)
      2'd1, 2'd2: pp_shift = pp_ext << HALF;
      2'd3:       pp_shift = pp_ext << WIDTH;
      default:    pp_shift = pp_ext;
    endcase
  end

  assign acc_sum = acc_q + pp_shift;

  always_comb begin
    // NOTE: every next-state signal gets a default first. Without it, a path that
    // skips an assignment infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    step_d  = step_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          mask_d  = approx_mask;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d  = acc_sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          y_d     = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the captured operands are reset too, not only the control state. This
  // keeps an aborted transaction from leaving visible residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      y_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so all registers update from the same pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_pp_mult_sched.sv
// Self-checking bench for pp_mult_sched. A negedge monitor scores every result
// against an arithmetic model. Directed and random transactions drive the DUT.
module tb_pp_mult_sched;

  localparam int TRUNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [3:0]  approx_mask = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] y;

  pp_mult_sched #(.WIDTH(8), .TRUNC_BITS(TRUNC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_mask(approx_mask), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  // Reference: split into nibbles, form the four products, truncate the masked ones, weight and sum.
  function automatic logic [15:0] ref_mult(input logic [7:0] x, input logic [7:0] z,
                                           input logic [3:0] m);
    int lo_x, hi_x, lo_z, hi_z, pp, sum;
    int weight [4];
    weight = '{1, 16, 16, 256};
    lo_x = int'(x) % 16;  hi_x = int'(x) / 16;
    lo_z = int'(z) % 16;  hi_z = int'(z) / 16;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      pp = ((k >= 2) ? hi_x : lo_x) * ((k % 2 == 1) ? hi_z : lo_z);
      if (m[k]) pp = pp - (pp % (1 << TRUNC));
      sum += pp * weight[k];
    end
    return 16'(sum);
  endfunction

  logic [15:0] exp_q [$];
  int          n_acc = 0;
  int          acc_cyc = 0;
  int          last_acc = 0;
  bit          have_last = 1'b0;
  bit          b2b_mode = 1'b0;
  bit          mon_en = 1'b0;
  bit          ov_prev = 1'b0;
  logic [15:0] last_y = '0;
  logic [15:0] y_prev = '0;

  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en) begin
      check("ready_vs_busy", {31'b0, in_ready}, {31'b0, !busy});
      if (out_valid) begin
        if (!ov_prev) begin
          check("latency", cyc - acc_cyc, 4);
          if (exp_q.size() == 0) check("unexpected_result", 0, 1);
          else check("y_at_valid", {16'b0, y}, {16'b0, exp_q[0]});
        end else begin
          check("y_stable", {16'b0, y}, {16'b0, y_prev});
        end
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          last_y = y;
        end
      end else begin
        check("y_hold", {16'b0, y}, {16'b0, last_y});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mult(a, b, approx_mask));
        n_acc++;
        if (b2b_mode && have_last) check("accept_spacing", cyc + 1 - last_acc, 6);
        acc_cyc   = cyc + 1;
        last_acc  = acc_cyc;
        have_last = 1'b1;
      end
      ov_prev = out_valid;
      y_prev  = y;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  // One transaction: accept, optional junk on inputs while busy, stall, handshake.
  task automatic txn(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] tm,
                     input int stall, input bit hold_busy);
    int n0, n;
    wait_ready();
    n0 = n_acc;
    a = ta; b = tb_v; approx_mask = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    check("accepted", n_acc, n0 + 1);
    if (hold_busy) begin
      a = 8'hAA; b = 8'h55; approx_mask = 4'hF;
    end else begin
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); approx_mask = 4'($urandom);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {31'b0, out_valid}, 1);
    check("ready_in_done", {31'b0, in_ready}, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("ready_after_hs", {31'b0, in_ready}, 1);
    check("one_accept", n_acc, n0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [3:0] pm [3];
    int n0, n;

    #12;
    check("rst_in_ready", {31'b0, in_ready}, 1);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_y", {16'b0, y}, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    txn(8'h12, 8'h34, 4'b0000, 0, 1'b0);
    check("y_12x34", {16'b0, last_y}, 32'h03A8);
    txn(8'hFF, 8'hFF, 4'b0000, 1, 1'b0);
    check("y_ffxff_exact", {16'b0, last_y}, 32'hFE01);
    txn(8'hFF, 8'hFF, 4'b1111, 0, 1'b0);
    check("y_ffxff_approx", {16'b0, last_y}, 32'hFCE0);
    txn(8'h03, 8'h03, 4'b0001, 0, 1'b0);
    check("y_3x3_m0001", {16'b0, last_y}, 32'h0008);
    txn(8'h03, 8'h03, 4'b1110, 2, 1'b0);
    check("y_3x3_m1110", {16'b0, last_y}, 32'h0009);
    txn(8'h5C, 8'hA7, 4'b0000, 3, 1'b1);
    check("y_backpressure", {16'b0, last_y}, 32'h3C04);

    // Abort during MUL step 2.
    wait_ready();
    a = 8'h77; b = 8'h99; approx_mask = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("abort_out_valid", {31'b0, out_valid}, 0);
    check("abort_y", {16'b0, y}, 0);
    check("abort_in_ready", {31'b0, in_ready}, 1);
    check("abort_busy", {31'b0, busy}, 0);
    exp_q.delete();
    ov_prev = 1'b0;
    last_y  = '0;
    y_prev  = '0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    txn(8'h00, 8'h5A, 4'b0000, 0, 1'b0);
    check("y_after_abort", {16'b0, last_y}, 0);

    for (int i = 0; i < 24; i++) begin
      txn(8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
    end

    // Back-to-back with in_valid and out_ready held high.
    pa = '{8'hC3, 8'h7E, 8'h19};
    pb = '{8'h2D, 8'hF0, 8'hB6};
    pm = '{4'b0000, 4'b0101, 4'b1010};
    wait_ready();
    b2b_mode  = 1'b1;
    have_last = 1'b0;
    n0 = n_acc;
    a = pa[0]; b = pb[0]; approx_mask = pm[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (n_acc <= n0 + i && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      if (n_acc <= n0 + i) check("b2b_accept_timeout", 0, 1);
      if (i < 2) begin
        a = pa[i+1]; b = pb[i+1]; approx_mask = pm[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_drained", exp_q.size(), 0);
    out_ready = 1'b0;
    b2b_mode  = 1'b0;
    check("b2b_accepts", n_acc, n0 + 3);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
